// File: rtl/min_sec_pkg.sv
// min_sec_pkg: shared widths, BCD limits and defaults for the minutes/seconds counter. Rev 1.0
`default_nettype none

package min_sec_pkg;

   localparam int unsigned DIGIT_W          = 4;
   localparam int unsigned PAIR_W           = 8;
   localparam int unsigned PRESC_W          = 8;
   localparam int unsigned TICK_DIV_DEFAULT = 4;

   localparam logic [DIGIT_W-1:0] TENS_MAX  = 4'd5;
   localparam logic [DIGIT_W-1:0] UNITS_MAX = 4'd9;

   // A digit pair is a legal 00..59 value only if both digits are in range.
   function automatic logic bcd_pair_valid(input logic [PAIR_W-1:0] pair);
      return (pair[PAIR_W-1:DIGIT_W] <= TENS_MAX) && (pair[DIGIT_W-1:0] <= UNITS_MAX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mod60.sv
// bcd_mod60: two-digit BCD modulo-60 register with synchronous preset and carry-out. Rev 1.0
`default_nettype none

module bcd_mod60
   import min_sec_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              inc,
   input  logic              load,
   input  logic [PAIR_W-1:0] d_in,
   output logic [PAIR_W-1:0] q,
   output logic              carry
);

   logic [PAIR_W-1:0] q_next;

   always_comb begin
      q_next = q;
      if (load) begin
         q_next = d_in;
      end else if (inc) begin
         if (q[DIGIT_W-1:0] == UNITS_MAX) begin
            q_next[DIGIT_W-1:0] = '0;
            q_next[PAIR_W-1:DIGIT_W] = (q[PAIR_W-1:DIGIT_W] == TENS_MAX) ? '0
                                       : q[PAIR_W-1:DIGIT_W] + 4'd1;
         end else begin
            q_next[DIGIT_W-1:0] = q[DIGIT_W-1:0] + 4'd1;
         end
      end
   end

   // Carry is combinational so the next stage advances on the same edge.
   assign carry = inc && !load && (q == {TENS_MAX, UNITS_MAX});

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else begin
         q <= q_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/min_sec_counter.sv
// min_sec_counter: prescaled BCD mm:ss counter with preset, rollover tick and load-error pulse. Rev 1.0
`default_nettype none

module min_sec_counter
   import min_sec_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   input  logic              load,
   input  logic [PAIR_W-1:0] d_in_sec,
   input  logic [PAIR_W-1:0] d_in_min,
   output logic [PAIR_W-1:0] sec_out,
   output logic [PAIR_W-1:0] min_out,
   output logic              hour_tick,
   output logic              load_err
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic [PRESC_W-1:0] presc;
   logic               load_ok;
   logic               load_bad;
   logic               presc_wrap;
   logic               sec_inc;
   logic               sec_carry;
   logic               min_carry;

   assign load_ok    = load && bcd_pair_valid(d_in_sec) && bcd_pair_valid(d_in_min);
   assign load_bad   = load && !load_ok;
   assign presc_wrap = (presc == PRESC_LAST);
   // Any load, accepted or not, masks the enable on that edge.
   assign sec_inc    = !load && en && presc_wrap;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc <= '0;
      end else if (load_ok) begin
         presc <= '0;
      end else if (!load && en) begin
         presc <= presc_wrap ? '0 : presc + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hour_tick <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         hour_tick <= min_carry;
         load_err  <= load_bad;
      end
   end

   bcd_mod60 u_sec (
      .clock (clock),
      .reset (reset),
      .inc   (sec_inc),
      .load  (load_ok),
      .d_in  (d_in_sec),
      .q     (sec_out),
      .carry (sec_carry)
   );

   bcd_mod60 u_min (
      .clock (clock),
      .reset (reset),
      .inc   (sec_carry),
      .load  (load_ok),
      .d_in  (d_in_min),
      .q     (min_out),
      .carry (min_carry)
   );

endmodule

`default_nettype wire

// File: tb/tb_min_sec_counter.sv
// tb_min_sec_counter: table-driven directed vectors plus hand-written reset and divide-by-one sequences.
`default_nettype none

module tb_min_sec_counter;

   logic       clock;
   logic       reset;
   logic       en;
   logic       load;
   logic [7:0] d_in_sec;
   logic [7:0] d_in_min;
   logic [7:0] sec_out;
   logic [7:0] min_out;
   logic       hour_tick;
   logic       load_err;

   logic       en1;
   logic       load1;
   logic [7:0] sec1;
   logic [7:0] min1;
   logic       ht1;
   logic       le1;

   int applied;
   int miscompares;

   min_sec_counter #(.TICK_DIV(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .en        (en),
      .load      (load),
      .d_in_sec  (d_in_sec),
      .d_in_min  (d_in_min),
      .sec_out   (sec_out),
      .min_out   (min_out),
      .hour_tick (hour_tick),
      .load_err  (load_err)
   );

   min_sec_counter #(.TICK_DIV(1)) dut1 (
      .clock     (clock),
      .reset     (reset),
      .en        (en1),
      .load      (load1),
      .d_in_sec  (8'h00),
      .d_in_min  (8'h00),
      .sec_out   (sec1),
      .min_out   (min1),
      .hour_tick (ht1),
      .load_err  (le1)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic       en;
      logic       load;
      logic [7:0] ds;
      logic [7:0] dm;
      int         reps;
      logic [7:0] es;
      logic [7:0] em;
      logic       eht;
      logic       ele;
   } vec_t;

   vec_t vt[$];

   function automatic void add(input logic e, input logic l, input logic [7:0] ds,
                               input logic [7:0] dm, input int reps, input logic [7:0] es,
                               input logic [7:0] em, input logic eht, input logic ele);
      vec_t v;
      v.en = e; v.load = l; v.ds = ds; v.dm = dm; v.reps = reps;
      v.es = es; v.em = em; v.eht = eht; v.ele = ele;
      vt.push_back(v);
   endfunction

   task automatic check(input string name, input logic [7:0] s, input logic [7:0] m,
                        input logic ht, input logic le,
                        input logic [7:0] es, input logic [7:0] em,
                        input logic eht, input logic ele);
      applied++;
      if (s !== es || m !== em || ht !== eht || le !== ele) begin
         miscompares++;
         $display("FAIL %s: got min=%h sec=%h hour_tick=%b load_err=%b, want min=%h sec=%h hour_tick=%b load_err=%b",
                  name, m, s, ht, le, em, es, eht, ele);
      end
   endtask

   task automatic edge_check(input string name, input logic [7:0] es, input logic [7:0] em,
                             input logic eht, input logic ele);
      @(posedge clock);
      #1;
      check(name, sec_out, min_out, hour_tick, load_err, es, em, eht, ele);
   endtask

   initial begin
      applied     = 0;
      miscompares = 0;
      reset    = 1'b0;
      en       = 1'b0;
      load     = 1'b0;
      d_in_sec = 8'h00;
      d_in_min = 8'h00;
      en1      = 1'b0;
      load1    = 1'b0;

      //        en load  ds     dm    reps  es     em   ht  le
      add(1'b0, 1'b1, 8'h09, 8'h00, 1,  8'h09, 8'h00, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 2,  8'h09, 8'h00, 0, 0);
      add(1'b0, 1'b0, 8'h00, 8'h00, 10, 8'h09, 8'h00, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 1,  8'h09, 8'h00, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 1,  8'h10, 8'h00, 0, 0);
      add(1'b0, 1'b1, 8'h34, 8'h12, 1,  8'h34, 8'h12, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 2,  8'h34, 8'h12, 0, 0);
      add(1'b1, 1'b1, 8'h60, 8'h12, 1,  8'h34, 8'h12, 0, 1);
      add(1'b0, 1'b0, 8'h00, 8'h00, 1,  8'h34, 8'h12, 0, 0);
      add(1'b0, 1'b1, 8'h0A, 8'h12, 1,  8'h34, 8'h12, 0, 1);
      add(1'b0, 1'b1, 8'h00, 8'h60, 1,  8'h34, 8'h12, 0, 1);
      add(1'b1, 1'b0, 8'h00, 8'h00, 1,  8'h34, 8'h12, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 1,  8'h35, 8'h12, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 2,  8'h35, 8'h12, 0, 0);
      add(1'b1, 1'b1, 8'h00, 8'h00, 1,  8'h00, 8'h00, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 3,  8'h00, 8'h00, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 1,  8'h01, 8'h00, 0, 0);
      add(1'b0, 1'b1, 8'h59, 8'h09, 1,  8'h59, 8'h09, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 3,  8'h59, 8'h09, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 1,  8'h00, 8'h10, 0, 0);
      add(1'b0, 1'b1, 8'h58, 8'h59, 1,  8'h58, 8'h59, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 3,  8'h58, 8'h59, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 1,  8'h59, 8'h59, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 3,  8'h59, 8'h59, 0, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 1,  8'h00, 8'h00, 1, 0);
      add(1'b1, 1'b0, 8'h00, 8'h00, 1,  8'h00, 8'h00, 0, 0);
      add(1'b0, 1'b0, 8'h00, 8'h00, 2,  8'h00, 8'h00, 0, 0);

      #3;
      check("reset_state", sec_out, min_out, hour_tick, load_err, 8'h00, 8'h00, 1'b0, 1'b0);
      #9 reset = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         for (int r = 0; r < vt[i].reps; r++) begin
            en       = vt[i].en;
            load     = vt[i].load;
            d_in_sec = vt[i].ds;
            d_in_min = vt[i].dm;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d.%0d", i, r), sec_out, min_out, hour_tick, load_err,
                  vt[i].es, vt[i].em, vt[i].eht, vt[i].ele);
         end
      end

      // Reset landing in the middle of an hour_tick pulse.
      en = 1'b0; load = 1'b1; d_in_sec = 8'h59; d_in_min = 8'h59;
      edge_check("pre_tick_load", 8'h59, 8'h59, 1'b0, 1'b0);
      load = 1'b0; en = 1'b1;
      for (int k = 0; k < 3; k++) edge_check("pre_tick_run", 8'h59, 8'h59, 1'b0, 1'b0);
      edge_check("tick_pulse", 8'h00, 8'h00, 1'b1, 1'b0);
      #2 reset = 1'b0;
      #1 check("async_rst_tick", sec_out, min_out, hour_tick, load_err, 8'h00, 8'h00, 1'b0, 1'b0);
      en = 1'b0;
      reset = 1'b1;

      // Reset landing in the middle of a load_err pulse with a nonzero time.
      load = 1'b1; d_in_sec = 8'h12; d_in_min = 8'h12;
      edge_check("pre_err_load", 8'h12, 8'h12, 1'b0, 1'b0);
      d_in_sec = 8'h70;
      edge_check("err_pulse", 8'h12, 8'h12, 1'b0, 1'b1);
      #2 reset = 1'b0;
      #1 check("async_rst_err", sec_out, min_out, hour_tick, load_err, 8'h00, 8'h00, 1'b0, 1'b0);

      // Load and enable present on the first edge after release.
      load = 1'b1; en = 1'b1; d_in_sec = 8'h21; d_in_min = 8'h00;
      #1 reset = 1'b1;
      edge_check("release_load", 8'h21, 8'h00, 1'b0, 1'b0);
      load = 1'b0; en = 1'b0;

      en1 = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clock);
         #1;
         check($sformatf("div1_%0d", k), sec1, min1, ht1, le1, 8'(k), 8'h00, 1'b0, 1'b0);
      end
      en1 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got still running, want finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/min_sec_counter.md
MIN_SEC_COUNTER -- requirements
Module: min_sec_counter

Interface
REQ-001 Parameter: TICK_DIV, default 4, number of enabled clock cycles per one-second advance (legal values 1..255).
REQ-002 Port: clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: en  in  1  count enable; when high, the prescaler advances.
REQ-005 Port: load  in  1  synchronous preset strobe for the time registers.
REQ-006 Port: d_in_sec  in  8  preset seconds, two BCD digits [7:4] tens, [3:0] units.
REQ-007 Port: d_in_min  in  8  preset minutes, BCD, same layout as d_in_sec.
REQ-008 Port: sec_out  out  8  current seconds, BCD, registered.
REQ-009 Port: min_out  out  8  current minutes, BCD, registered.
REQ-010 Port: hour_tick  out  1  one-cycle pulse on the 59:59 to 00:00 rollover; drives the count enable of the downstream mod-12 hour counter.
REQ-011 Port: load_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-012 All outputs SHALL be registered, and a value SHALL change on the same clock edge that causes it (zero extra latency).
REQ-013 Priority per edge SHALL be: reset, then load, then en, then hold.
REQ-014 Valid load: both digit pairs have tens <= 5 and units <= 9. A valid load SHALL copy d_in_sec/d_in_min into sec_out/min_out, clear the prescaler and drive hour_tick=0.
REQ-015 Invalid load SHALL leave time and prescaler unchanged and assert load_err for exactly the following cycle. en is ignored on that edge.
REQ-016 With load=0 and en=1, the prescaler SHALL increment. When the prescaler equals TICK_DIV-1, it SHALL return to 0 and the time SHALL advance by one second on that edge.
REQ-017 Seconds units SHALL wrap 9 to 0 and carry into tens. Seconds 59 SHALL wrap to 00 and carry into minutes. Minutes SHALL follow the same rule.
REQ-018 On the advance from 59:59, outputs SHALL become 00:00 and hour_tick=1 on the same edge. hour_tick SHALL drop on the next edge.
REQ-019 With en=0 and load=0, time and prescaler SHALL hold; the prescaler SHALL resume without restarting.
REQ-020 TICK_DIV=1 SHALL advance the time on every enabled cycle.
REQ-021 hour_tick and load_err SHALL never be asserted on the same cycle.

Reset
REQ-022 reset low SHALL immediately force sec_out=00, min_out=00, hour_tick=0, load_err=0 and prescaler=0, regardless of clock.
REQ-023 Deassertion SHALL take effect on the first rising edge after reset returns high. A load or en present on that edge SHALL be honoured.
REQ-024 Reset asserted mid-count or mid-pulse SHALL abort any pending hour_tick or load_err.

Structure
REQ-025 Package min_sec_pkg SHALL hold: BCD digit width (4), digit-pair width (8), TENS_MAX=5, UNITS_MAX=9, and the TICK_DIV default.
REQ-026 Sub-module bcd_mod60 (inputs inc, load, d_in; outputs q, carry) SHALL be instanced twice, once for seconds and once for minutes. The seconds carry SHALL feed the minutes inc.
REQ-027 The prescaler and the hour_tick/load_err pulse registers SHALL live in min_sec_counter.

Verification
REQ-028 Async reset: reset low between edges mid-count -> sec_out=00, min_out=00, all pulses 0 before the next edge.
REQ-029 Hour rollover: TICK_DIV=4, load sec=0x58 and min=0x59, then en=1 -> 59:59 after 4 clocks; 00:00 with hour_tick=1 for one cycle after 8 clocks.
REQ-030 Invalid load: time at 12:34, load with d_in_sec=0x60 (or 0x0A) -> load_err=1 for one cycle, time stays 12:34.
REQ-031 Load and en together with prescaler=2 -> loaded value appears, prescaler=0, no advance on that edge.
REQ-032 Enable gap: en=1 for 2 cycles, en=0 for 10 cycles, en=1 for 2 cycles -> exactly one advance, with sec_out going 0x09 to 0x10 when starting from 0x09.
